// File: rtl/freq_meas_ctrl.sv
// Auto-ranging gate scheduler for the frequency meter: clears and gates an external
// edge counter, steps the range until the count sits in the hysteresis band, publishes Hz.
module freq_meas_ctrl #(
    parameter int unsigned GATE0  = 1000,
    parameter int unsigned HI_TH  = 100000,
    parameter int unsigned LO_TH  = 9000,
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk_1k,
    input  logic        Rst_n,
    input  logic        start,
    input  logic [23:0] cnt_val,
    output logic        gate,
    output logic        cnt_clr,
    output logic [1:0]  range,
    output logic [23:0] result,
    output logic        over,
    output logic        valid,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_SETTLE,
        S_EVAL
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] tmr;
    logic [15:0] gate_len;
    logic        last_gate;
    logic        last_settle;
    logic [30:0] mult;
    logic [30:0] prod;
    logic        step_up;
    logic        step_dn;

    always_comb begin
        case (range)
            2'd0:    begin gate_len = 16'(GATE0);       mult = 31'd1;   end
            2'd1:    begin gate_len = 16'(GATE0 / 10);  mult = 31'd10;  end
            default: begin gate_len = 16'(GATE0 / 100); mult = 31'd100; end
        endcase
    end

    assign last_gate   = (tmr == gate_len - 16'd1);
    assign last_settle = (tmr == 16'(SETTLE - 1));
    // 24 x 7 bits fits in 31 bits, so the saturation test below sees the true product.
    assign prod        = {7'd0, cnt_val} * mult;
    assign step_up     = (cnt_val >= 24'(HI_TH)) && (range != 2'd2);
    assign step_dn     = (cnt_val <  24'(LO_TH)) && (range != 2'd0);

    always_ff @(posedge clk_1k or negedge Rst_n) begin
        // NOTE: non-blocking assignments keep every register update on the same edge
        // independent of statement order.
        if (!Rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gate      = 1'b0;
        cnt_clr   = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                cnt_clr   = 1'b1;
                state_nxt = start ? S_GATE : S_IDLE;
            end
            S_GATE: begin
                gate = 1'b1;
                if (!start)         state_nxt = S_IDLE;
                else if (last_gate) state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (!start)           state_nxt = S_IDLE;
                else if (last_settle) state_nxt = S_EVAL;
            end
            S_EVAL:  state_nxt = start ? S_CLEAR : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Window timer restarts on every state change and only runs while timing a window.
    always_ff @(posedge clk_1k or negedge Rst_n) begin
        if (!Rst_n)                                     tmr <= '0;
        else if (state_nxt != state)                    tmr <= '0;
        else if (state == S_GATE || state == S_SETTLE)  tmr <= tmr + 16'd1;
    end

    always_ff @(posedge clk_1k or negedge Rst_n) begin
        if (!Rst_n) begin
            range  <= 2'd0;
            result <= '0;
            over   <= 1'b0;
            valid  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == S_EVAL) begin
                if (step_up) begin
                    range <= range + 2'd1;
                end else if (step_dn) begin
                    range <= range - 2'd1;
                end else begin
                    valid <= 1'b1;
                    if (prod > 31'h00FF_FFFF) begin
                        result <= 24'hFF_FFFF;
                        over   <= 1'b1;
                    end else begin
                        result <= prod[23:0];
                        over   <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/freq_meas_ctrl.md
# freq_meas_ctrl

Auto-ranging measurement scheduler for the digital frequency meter. It drives an external gated edge counter that runs in the input-signal domain: it clears the counter, opens a gate window of a selected length and samples the stable count after settling. It then steps the gate range up or down until the count lies inside a hysteresis band, and publishes a binary frequency in Hz with a one-cycle valid strobe to the downstream BCD/display path.

## Interface
- GATE0, 1000: gate length in clk_1k cycles at range 0 (1 s); range 1 = GATE0/10, range 2 = GATE0/100
- HI_TH, 100000: count at or above this steps the range up (shorter gate)
- LO_TH, 9000: count below this steps the range down (longer gate)
- SETTLE, 2: cycles waited after gate falls before sampling cnt_val (CDC settling)
- clk_1k  in  1  system tick clock, rising-edge active
- Rst_n  in  1  reset, asynchronous, active-low
- start  in  1  level; high = measure continuously, low = stop/abort
- cnt_val  in  24  binary edge count from external counter; stable only while gate is low
- gate  out  1  counter enable window
- cnt_clr  out  1  one-cycle clear pulse to external counter
- range  out  2  current range 0..2 (3 never produced)
- result  out  24  frequency in Hz, binary
- over  out  1  result saturated; valid with result
- valid  out  1  one-cycle strobe, result/over updated same cycle
- busy  out  1  high in every state except IDLE

## Operation
- One clock domain (clk_1k) and one reset: asynchronous, active-low Rst_n. Reset values: state IDLE, gate 0, cnt_clr 0, range 0, result 0, over 0, valid 0, busy 0, all internal counters 0.
- FSM states: IDLE, CLEAR, GATE, SETTLE, EVAL.
  - IDLE: if start=1 go to CLEAR.
  - CLEAR: cnt_clr=1 for exactly this cycle; go to GATE.
  - GATE: gate=1 for exactly G cycles. G = GATE0 at range 0, GATE0/10 at range 1, GATE0/100 at range 2. Then go to SETTLE.
  - SETTLE: gate=0 for SETTLE cycles; go to EVAL.
  - EVAL: one cycle. Sample cnt_val and decide (below). Then go to CLEAR if start=1, else IDLE.
- EVAL decision:
  - cnt_val >= HI_TH and range<2: range+1, no valid, measurement discarded.
  - cnt_val < LO_TH and range>0: range-1, no valid, measurement discarded.
  - Otherwise publish. Product P = cnt_val × 10^range, computed at 31-bit width.
    - If P > 24'hFFFFFF: result=24'hFFFFFF, over=1.
    - Else result=P[23:0], over=0.
    - valid=1 for one cycle.
- Range is retained across measurements and across start low/high cycles; only reset returns it to 0.
- At range 2, a count >= HI_TH publishes (saturating if needed). At range 0, a count < LO_TH publishes, including 0.
- Abort: start=0 sampled in CLEAR, GATE or SETTLE gives IDLE on the next cycle. gate drops immediately, there is no valid, and result/over hold their old values.
- Asynchronous reset mid-window forces gate=0 and range=0 with no glitch-free guarantee on the external count.

## Timing
- start sampled high in IDLE at cycle 0:
  - CLEAR at cycle 1.
  - GATE at cycles 2..G+1.
  - SETTLE at cycles G+2..G+SETTLE+1.
  - EVAL at cycle G+SETTLE+2.
  - valid/result/over registered and visible at cycle G+SETTLE+3.
- Range 0 with defaults: valid at cycle 1005. Each back-to-back measurement period is 1+G+SETTLE+1 cycles (1004 at range 0).
- range output updates at the same edge as valid would (cycle after EVAL). The following GATE uses the new G.
- valid never asserts in two consecutive cycles. result is stable between valids.
- cnt_clr and gate are never high in the same cycle.

## Test plan
- Reset then start=1, bench counter models 5000 Hz (cnt_val=5000 at range 0) -> cnt_clr at cycle 1, gate high cycles 2..1001, valid at cycle 1005, result=5000, over=0, range=0.
- 250000 Hz from range 0 (cnt_val=250000) -> no valid at first EVAL, range=1. Next gate is 100 cycles, cnt_val=25000 -> result=250000 valid, range=1.
- At range 1, source drops to 50000 Hz (cnt_val=5000 < 9000) -> range=0, no valid. Next 1000-cycle gate gives cnt_val=50000 -> result=50000.
- At range 2, cnt_val=200000 (20 MHz) -> result=24'hFFFFFF, over=1, range stays 2. cnt_val=150000 -> result=15000000, over=0.
- start dropped at cycle 500 of a range-0 gate -> gate low and IDLE next cycle, no valid, result unchanged. Restart -> full 1005-cycle sequence.
- Rst_n pulsed low during GATE at range 2 -> gate=0, range=0, busy=0 immediately (asynchronous). No valid until a fresh start completes.
